// File: rtl/mont_mul_radix2_if.sv
// Level go/done handshake bundle between the exponentiation controller
// (master) and a Montgomery multiplier (slave).
// With MONT_MUL_CHECK_EN defined the bundle also carries the err flag.
interface mont_mul_radix2_if #(
    parameter int WIDTH = 4
);
    logic             go;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] M;
    logic             done;
    logic [WIDTH-1:0] S;
`ifdef MONT_MUL_CHECK_EN
    logic             err;

    modport master (output go, A, B, M, input  done, S, err);
    modport slave  (input  go, A, B, M, output done, S, err);
`else
    modport master (output go, A, B, M, input  done, S);
    modport slave  (input  go, A, B, M, output done, S);
`endif
endinterface

// File: rtl/mont_mul_radix2.sv
// Radix-2 bit-serial Montgomery multiplier: S = A*B*2^-WIDTH mod M.
// One multiplier bit per clock; fixed latency of WIDTH+2 edges from the
// edge that samples go=1 until done rises.
// Optional build macro MONT_MUL_CHECK_EN: adds operand legality checks and
// the err output (illegal operands short-cut to DONE with S=0, err=1).
module mont_mul_radix2 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    mont_mul_radix2_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_CALC  = 4'b0010,
        S_FINAL = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;       // shifted right each CALC cycle; bit 0 is the live multiplier bit
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH:0]   r_acc;     // partial result, always < 2*M
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_done;

    logic [WIDTH-1:0] w_addb;
    logic [WIDTH+1:0] w_t1;
    logic [WIDTH+1:0] w_t2;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_red;
    logic             w_last;
    logic             w_unused;

`ifdef MONT_MUL_CHECK_EN
    logic             r_bad;
    logic             r_err;
    logic             w_bad;

    // Operands are judged as presented on the start edge.
    assign w_bad = ~bus.M[0] | (bus.A >= bus.M) | (bus.B >= bus.M);
    assign bus.err = r_err;
`endif

    // One Montgomery step: add B if the current A bit is set, then add M if
    // odd so the sum divides cleanly by 2. WIDTH+2 bits holds acc+B+M < 4M.
    assign w_addb = r_a[0] ? r_b : '0;
    assign w_t1   = {1'b0, r_acc} + {2'b00, w_addb};
    assign w_t2   = w_t1 + (w_t1[0] ? {2'b00, r_m} : '0);

    // Final conditional subtraction; acc < 2M so one subtract fully reduces.
    assign w_sub  = r_acc - {1'b0, r_m};
    assign w_red  = (r_acc >= {1'b0, r_m}) ? w_sub[WIDTH-1:0] : r_acc[WIDTH-1:0];

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // t2[0] is always zero after the odd-fixup and the subtract's top bit is
    // discarded by construction.
    assign w_unused = ^{w_t2[0], w_sub[WIDTH]};

    assign bus.done = r_done;
    assign bus.S    = r_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: go low aborts anywhere except DONE, where it releases.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_next = S_CALC;
`ifdef MONT_MUL_CHECK_EN
                    if (w_bad) w_next = S_FINAL;
`endif
                end
            end
            S_CALC: begin
                if (!bus.go)    w_next = S_IDLE;
                else if (w_last) w_next = S_FINAL;
            end
            S_FINAL: w_next = bus.go ? S_DONE : S_IDLE;
            S_DONE:  if (!bus.go) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands on start, iterate in CALC, publish in FINAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_m    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_s    <= '0;
            r_done <= 1'b0;
`ifdef MONT_MUL_CHECK_EN
            r_bad  <= 1'b0;
            r_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_a   <= bus.A;
                        r_b   <= bus.B;
                        r_m   <= bus.M;
                        r_acc <= '0;
                        r_cnt <= '0;
`ifdef MONT_MUL_CHECK_EN
                        r_bad <= w_bad;
`endif
                    end
                end
                S_CALC: begin
                    if (bus.go) begin
                        r_acc <= w_t2[WIDTH+1:1];
                        r_a   <= r_a >> 1;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FINAL: begin
                    if (bus.go) begin
                        r_done <= 1'b1;
`ifdef MONT_MUL_CHECK_EN
                        r_err  <= r_bad;
                        r_s    <= r_bad ? '0 : w_red;
`else
                        r_s    <= w_red;
`endif
                    end
                end
                S_DONE: begin
                    if (!bus.go) begin
                        r_done <= 1'b0;
`ifdef MONT_MUL_CHECK_EN
                        r_err  <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul_radix2.sv
// Self-checking bench for mont_mul_radix2: a WIDTH=4 instance for the
// directed scenarios and a WIDTH=8 instance for random vectors. Expected
// results come from an independent modular-arithmetic reference and are
// queued at stimulus time, popped when done rises.
module tb_mont_mul_radix2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mont_mul_radix2_if #(.WIDTH(4)) b4();
    mont_mul_radix2_if #(.WIDTH(8)) b8();

    mont_mul_radix2 #(.WIDTH(4), .CNT_W(6)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    mont_mul_radix2 #(.WIDTH(8), .CNT_W(6)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    int checks   = 0;
    int failures = 0;
    int q4[$];
    int q8[$];
    int last_s   = 0;

    // A*B*R^-1 mod M via an explicit modular inverse of R.
    function automatic int mont_ref(int a, int b, int m, int w);
        longint r, rinv, p;
        r    = (longint'(1) << w) % m;
        rinv = 0;
        for (int x = 0; x < m; x++)
            if ((r * x) % m == 1) rinv = x;
        p = (((longint'(a) * b) % m) * rinv) % m;
        return int'(p);
    endfunction

    task automatic start4(input int a, input int b, input int m, input bit push);
        @(negedge clk);
        b4.go = 1'b1;
        b4.A  = a[3:0];
        b4.B  = b[3:0];
        b4.M  = m[3:0];
        if (push) q4.push_back(mont_ref(a, b, m, 4));
    endtask

    task automatic release4();
        @(negedge clk);
        b4.go = 1'b0;
    endtask

    // Edges until done (1 = the start edge), -1 if it never rises.
    task automatic wait4(output int n);
        n = -1;
        for (int i = 1; i <= 40 && n < 0; i++) begin
            @(posedge clk); #1;
            if (b4.done === 1'b1) n = i;
        end
    endtask

    task automatic pop4(output int e);
        if (q4.size() == 0) e = -1;
        else                e = q4.pop_front();
    endtask

    task automatic test_reset();
        int e;
        rst_n = 1'b0;
        b4.go = 1'b0; b4.A = '0; b4.B = '0; b4.M = '0;
        b8.go = 1'b0; b8.A = '0; b8.B = '0; b8.M = '0;
        repeat (2) @(posedge clk);
        #1;
        e = 0;
        checks++;
        if ({b4.done, b4.S} !== 5'(e)) begin
            failures++;
            $display("FAIL reset_state: done=%0b S=%0d expected done=0 S=0", b4.done, b4.S);
        end
`ifdef MONT_MUL_CHECK_EN
        checks++;
        if (b4.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: err=%0b expected 0", b4.err);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (b4.done !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start: done=%0b expected 0", b4.done);
        end
    endtask

    task automatic test_basic();
        int n, e;
        start4(7, 11, 13, 1);
        wait4(n);
        checks++;
        if (n !== 6) begin
            failures++;
            $display("FAIL basic_latency: edges=%0d expected 6", n);
        end
        pop4(e);
        checks++;
        if (b4.S !== 4'(e)) begin
            failures++;
            $display("FAIL basic_S: S=%0d expected %0d", b4.S, e);
        end
        // Inputs wiggle while go is held: result must not move or restart.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b4.A = 4'($urandom); b4.B = 4'($urandom); b4.M = 4'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({b4.done, b4.S} !== {1'b1, 4'(e)}) begin
                failures++;
                $display("FAIL hold_stable[%0d]: done=%0b S=%0d expected done=1 S=%0d", i, b4.done, b4.S, e);
            end
        end
        release4();
        @(posedge clk); #1;
        checks++;
        if ({b4.done, b4.S} !== {1'b0, 4'(e)}) begin
            failures++;
            $display("FAIL release: done=%0b S=%0d expected done=0 S=%0d", b4.done, b4.S, e);
        end
        last_s = e;
    endtask

    // Two back-to-back ops with go low for exactly one cycle between them.
    task automatic test_back_to_back(input int a0, input int b0, input int a1, input int b1);
        int n, e;
        start4(a0, b0, 13, 1);
        wait4(n);
        pop4(e);
        checks++;
        if (n !== 6 || b4.S !== 4'(e)) begin
            failures++;
            $display("FAIL b2b_first: edges=%0d S=%0d expected edges=6 S=%0d", n, b4.S, e);
        end
        release4();
        start4(a1, b1, 13, 1);
        wait4(n);
        pop4(e);
        checks++;
        if (n !== 6 || b4.S !== 4'(e)) begin
            failures++;
            $display("FAIL b2b_second: edges=%0d S=%0d expected edges=6 S=%0d", n, b4.S, e);
        end
        release4();
        last_s = e;
    endtask

    task automatic test_abort();
        int n, e;
        start4(3, 5, 13, 0);
        repeat (3) @(posedge clk);   // start edge + two CALC edges
        release4();                  // third CALC edge sees go=0
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({b4.done, b4.S} !== {1'b0, 4'(last_s)}) begin
                failures++;
                $display("FAIL abort_quiet[%0d]: done=%0b S=%0d expected done=0 S=%0d", i, b4.done, b4.S, last_s);
            end
        end
        start4(7, 11, 13, 1);
        wait4(n);
        pop4(e);
        checks++;
        if (n !== 6 || b4.S !== 4'(e)) begin
            failures++;
            $display("FAIL abort_restart: edges=%0d S=%0d expected edges=6 S=%0d", n, b4.S, e);
        end
        release4();
        last_s = e;
    endtask

    task automatic test_reset_mid();
        int n, e;
        start4(5, 6, 13, 0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b4.done, b4.S} !== 5'd0) begin
            failures++;
            $display("FAIL async_reset: done=%0b S=%0d expected done=0 S=0", b4.done, b4.S);
        end
        @(negedge clk);
        b4.go = 1'b0;
        rst_n = 1'b1;
        start4(12, 12, 13, 1);
        wait4(n);
        pop4(e);
        checks++;
        if (n !== 6 || b4.S !== 4'(e)) begin
            failures++;
            $display("FAIL post_reset_op: edges=%0d S=%0d expected edges=6 S=%0d", n, b4.S, e);
        end
        release4();
        last_s = e;
    endtask

`ifdef MONT_MUL_CHECK_EN
    task automatic test_check();
        int n;
        start4(1, 1, 12, 0);
        wait4(n);
        checks++;
        if (n !== 2 || b4.err !== 1'b1 || b4.S !== 4'd0) begin
            failures++;
            $display("FAIL check_even_M: edges=%0d err=%0b S=%0d expected edges=2 err=1 S=0", n, b4.err, b4.S);
        end
        release4();
        @(posedge clk); #1;
        checks++;
        if ({b4.done, b4.err} !== 2'b00) begin
            failures++;
            $display("FAIL check_clear: done=%0b err=%0b expected 0 0", b4.done, b4.err);
        end
        start4(13, 2, 13, 0);
        wait4(n);
        checks++;
        if (n !== 2 || b4.err !== 1'b1) begin
            failures++;
            $display("FAIL check_A_ge_M: edges=%0d err=%0b expected edges=2 err=1", n, b4.err);
        end
        release4();
        start4(7, 11, 13, 0);
        wait4(n);
        checks++;
        if (n !== 6 || b4.err !== 1'b0 || b4.S !== 4'd4) begin
            failures++;
            $display("FAIL check_legal: edges=%0d err=%0b S=%0d expected edges=6 err=0 S=4", n, b4.err, b4.S);
        end
        release4();
    endtask
`endif

    task automatic test_random8();
        int a, b, m, n, e;
        for (int v = 0; v < 1000; v++) begin
            m = $urandom_range(127, 1) * 2 + 1;
            a = $urandom_range(m - 1, 0);
            b = $urandom_range(m - 1, 0);
            @(negedge clk);
            b8.go = 1'b1;
            b8.A  = a[7:0];
            b8.B  = b[7:0];
            b8.M  = m[7:0];
            q8.push_back(mont_ref(a, b, m, 8));
            n = -1;
            for (int i = 1; i <= 40 && n < 0; i++) begin
                @(posedge clk); #1;
                if (b8.done === 1'b1) n = i;
            end
            e = (q8.size() == 0) ? -1 : q8.pop_front();
            checks++;
            if (n !== 10 || b8.S !== 8'(e)) begin
                failures++;
                $display("FAIL rand8[%0d] A=%0d B=%0d M=%0d: edges=%0d S=%0d expected edges=10 S=%0d",
                         v, a, b, m, n, b8.S, e);
            end
            @(negedge clk);
            b8.go = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back(1, 9, 12, 12);
        test_back_to_back(0, 11, 12, 1);
        test_abort();
        test_reset_mid();
`ifdef MONT_MUL_CHECK_EN
        test_check();
`endif
        test_random8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
